// File: rtl/snn_pkg.sv
// Shared definitions for the SNN readout stage: FSM state encoding and default sizes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snn_pkg;

    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_COUNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCAN  = 2'd2
    } wta_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating per-class spike counter with synchronous clear and count enable.
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: clk_i/rst_i clock and async active-high reset; clr_i sync clear
// (wins over en_i); en_i count request; count_o current count.
module sat_counter #(
    parameter int COUNT_W = snn_pkg::DEF_COUNT_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [COUNT_W-1:0] count_o
);

    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clr_i) begin
            count_o <= '0;
        end else if (en_i && (count_o != CNT_MAX)) begin
            count_o <= count_o + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/spike_readout_wta.sv
// Winner-take-all readout: counts output-layer spikes over a fixed window, then scans for the max class.
// Latency: WINDOW_LEN + NUM_CLASSES - 1 edges from accepted start to the valid_o pulse.
// Backpressure: none; start_i is only accepted in IDLE, results hold until the next valid_o.
//
// Ports: clk_i/rst_i clock and async active-high reset; start_i opens a window;
// spike_i one bit per class; busy_o window or scan in progress; valid_o result
// pulse; class_o/max_count_o/tie_o winning index, its count, equal-max flag.
module spike_readout_wta
    import snn_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int COUNT_W     = DEF_COUNT_W,
    parameter int WINDOW_LEN  = 64,
    parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [NUM_CLASSES-1:0] spike_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [IDX_W-1:0]       class_o,
    output logic [COUNT_W-1:0]     max_count_o,
    output logic                   tie_o
);

    localparam int                 WIN_W    = $clog2(WINDOW_LEN + 1);
    localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};

    wta_state_t         state;
    logic [WIN_W-1:0]   win_cnt;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx;
    logic [COUNT_W-1:0] best;
    logic               tie;

    logic [COUNT_W-1:0] cnt [NUM_CLASSES];
    logic               win_clr;
    logic               accum_en;

    assign win_clr  = (state == IDLE) && start_i;
    assign accum_en = (state == ACCUM);

    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_cnt
        sat_counter #(
            .COUNT_W (COUNT_W)
        ) u_cnt (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clr_i   (win_clr),
            .en_i    (accum_en && spike_i[g]),
            .count_o (cnt[g])
        );
    end

    // The scan seed is loaded on the same edge that samples the last spike, so
    // class 0's count must include that final sample before it lands in cnt[0].
    logic [COUNT_W-1:0] cnt0_final;
    assign cnt0_final = (spike_i[0] && (cnt[0] != CNT_MAX)) ? cnt[0] + COUNT_W'(1) : cnt[0];

    // One comparison per SCAN cycle; a strictly greater count takes over and
    // clears the tie, an equal count keeps the lower index and flags a tie.
    logic [COUNT_W-1:0] scan_cnt;
    logic [COUNT_W-1:0] best_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               tie_nxt;

    always_comb begin
        scan_cnt = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (scan_idx == IDX_W'(k)) begin
                scan_cnt = cnt[k];
            end
        end
        best_nxt = best;
        idx_nxt  = best_idx;
        tie_nxt  = tie;
        if (scan_cnt > best) begin
            best_nxt = scan_cnt;
            idx_nxt  = scan_idx;
            tie_nxt  = 1'b0;
        end else if (scan_cnt == best) begin
            tie_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            win_cnt     <= '0;
            scan_idx    <= '0;
            best_idx    <= '0;
            best        <= '0;
            tie         <= 1'b0;
            busy_o      <= 1'b0;
            valid_o     <= 1'b0;
            class_o     <= '0;
            max_count_o <= '0;
            tie_o       <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state   <= ACCUM;
                        win_cnt <= '0;
                        busy_o  <= 1'b1;
                    end
                end
                ACCUM: begin
                    win_cnt <= win_cnt + WIN_W'(1);
                    if (win_cnt == WIN_LAST) begin
                        state    <= SCAN;
                        best_idx <= '0;
                        best     <= cnt0_final;
                        tie      <= 1'b0;
                        scan_idx <= IDX_W'(1);
                    end
                end
                SCAN: begin
                    best     <= best_nxt;
                    best_idx <= idx_nxt;
                    tie      <= tie_nxt;
                    scan_idx <= scan_idx + IDX_W'(1);
                    if (scan_idx == IDX_LAST) begin
                        class_o     <= idx_nxt;
                        max_count_o <= best_nxt;
                        tie_o       <= tie_nxt;
                        valid_o     <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_readout_wta.sv
module tb_spike_readout_wta;

    localparam int NC  = 10;
    localparam int CW  = 6;
    localparam int WL  = 64;
    localparam int IW  = 4;
    localparam int LAT = WL + NC - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [NC-1:0] spike_i = '0;
    logic          busy_o;
    logic          valid_o;
    logic [IW-1:0] class_o;
    logic [CW-1:0] max_count_o;
    logic          tie_o;

    int vectors = 0;
    int miscompares = 0;
    int valid_seen = 0;
    int held_cls = 0;
    int held_max = 0;
    int held_tie = 0;

    spike_readout_wta #(
        .NUM_CLASSES (NC),
        .COUNT_W     (CW),
        .WINDOW_LEN  (WL),
        .IDX_W       (IW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .spike_i     (spike_i),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .class_o     (class_o),
        .max_count_o (max_count_o),
        .tie_o       (tie_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (valid_o) valid_seen <= valid_seen + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Spike pattern for ACCUM sample c (1..WL).
    function automatic logic [NC-1:0] pat(input int mode, input int c);
        logic [NC-1:0] p;
        p = '0;
        case (mode)
            0: p[3] = 1'b1;
            1: if (c % 2 == 0) begin p[2] = 1'b1; p[7] = 1'b1; end
            5: if (c <= 10) p[5] = 1'b1;
            6: begin
                if (c <= 5) begin p[0] = 1'b1; p[6] = 1'b1; end
                if (c <= 7) p[9] = 1'b1;
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // pre: E0 has already happened (start was raised on the previous valid cycle).
    // b2b: raise start on this window's valid cycle.
    task automatic run_window(input string tag, input int mode, input bit pre, input bit b2b,
                              input int exp_cls, input int exp_max, input int exp_tie);
        int edges;
        int scan_cyc;
        bit got_valid;
        if (!pre) begin
            @(negedge clk_i);
            start_i = 1'b1;
            spike_i = '0;
            @(posedge clk_i);
        end
        edges = 0;
        for (int c = 1; c <= WL; c++) begin
            if (!(c == 1 && pre)) @(negedge clk_i);
            if (c == 1) begin
                chk({tag, "_busy"}, busy_o, 1);
                chk({tag, "_held_cls"}, class_o, held_cls);
            end
            start_i = (mode == 3 && c == 10);
            spike_i = pat(mode, c);
            @(posedge clk_i);
            edges++;
        end
        got_valid = 1'b0;
        scan_cyc = 0;
        while (edges < 200) begin
            @(negedge clk_i);
            if (valid_o) begin
                got_valid = 1'b1;
                break;
            end
            if (edges == LAT - 1) chk({tag, "_held_max"}, max_count_o, held_max);
            spike_i = (mode == 3) ? 10'h200 : '0;
            start_i = (mode == 3 && scan_cyc == 0);
            scan_cyc++;
            @(posedge clk_i);
            edges++;
        end
        chk({tag, "_valid"}, got_valid, 1);
        chk({tag, "_lat"}, edges, LAT);
        chk({tag, "_cls"}, class_o, exp_cls);
        chk({tag, "_max"}, max_count_o, exp_max);
        chk({tag, "_tie"}, tie_o, exp_tie);
        held_cls = exp_cls;
        held_max = exp_max;
        held_tie = exp_tie;
        spike_i = '0;
        start_i = b2b;
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, "_vld_drop"}, valid_o, 0);
        chk({tag, "_busy_after"}, busy_o, b2b ? 1 : 0);
        if (!b2b) chk({tag, "_tie_hold"}, tie_o, held_tie);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_cls", class_o, 0);
        chk("rst_max", max_count_o, 0);
        chk("rst_tie", tie_o, 0);
        rst_i = 1'b0;

        run_window("single", 0, 1'b0, 1'b0, 3, 63, 0);
        run_window("tie", 1, 1'b0, 1'b0, 2, 32, 1);
        run_window("late_win", 6, 1'b0, 1'b0, 9, 7, 0);
        run_window("silence", 2, 1'b0, 1'b0, 0, 0, 1);

        v0 = valid_seen;
        run_window("ignored", 3, 1'b0, 1'b0, 0, 0, 1);
        repeat (20) @(negedge clk_i);
        chk("ignored_one_valid", valid_seen - v0, 1);
        chk("ignored_idle", busy_o, 0);

        // Reset 30 cycles into a window with class 5 spiking.
        @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            spike_i = 10'h020;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_cls", class_o, 0);
        chk("midrst_max", max_count_o, 0);
        chk("midrst_tie", tie_o, 0);
        held_cls = 0;
        held_max = 0;
        held_tie = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        spike_i = '0;

        run_window("fresh5", 5, 1'b0, 1'b1, 5, 10, 0);
        run_window("b2b", 0, 1'b1, 1'b0, 3, 63, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
